// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a saturating stall counter.
// Latency: one cycle from the ID inputs to the EX_* outputs. A load-use hazard inserts exactly one bubble.
// Backpressure: on a hazard, Stall is raised combinationally and drops PCWrite and IFIDWrite, so ID holds while EX takes a bubble.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Flush,
    input  logic [1:0]                ALUOp,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemtoReg,
    input  logic                      RegDst,
    input  logic                      RegWrite,
    input  logic                      ALUSrc,
    input  logic [DATA_WIDTH-1:0]     ReadData1,
    input  logic [DATA_WIDTH-1:0]     ReadData2,
    input  logic [DATA_WIDTH-1:0]     SignExtImm,
    input  logic [REG_ADDR_WIDTH-1:0] Rs,
    input  logic [REG_ADDR_WIDTH-1:0] Rt,
    input  logic [REG_ADDR_WIDTH-1:0] Rd,
    input  logic [5:0]                Funct,
    output logic                      Stall,
    output logic                      PCWrite,
    output logic                      IFIDWrite,
    output logic [1:0]                EX_ALUOp,
    output logic                      EX_MemRead,
    output logic                      EX_MemWrite,
    output logic                      EX_MemtoReg,
    output logic                      EX_RegDst,
    output logic                      EX_RegWrite,
    output logic                      EX_ALUSrc,
    output logic [DATA_WIDTH-1:0]     EX_ReadData1,
    output logic [DATA_WIDTH-1:0]     EX_ReadData2,
    output logic [DATA_WIDTH-1:0]     EX_Imm,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rs,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rt,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
    output logic [5:0]                EX_Funct,
    output logic                      EX_Valid,
    output logic [CNT_WIDTH-1:0]      StallCount
);

    // Control bits produced by the opcode control unit.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
    } ctrl_t;

    // Complete EX-stage payload. An all-zero value is a bubble.
    typedef struct packed {
        ctrl_t                     ctrl;
        logic [DATA_WIDTH-1:0]     read_data1;
        logic [DATA_WIDTH-1:0]     read_data2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [5:0]                funct;
        logic                      valid;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t id_bundle;
    ex_bundle_t ex_next;

    logic uses_rt;
    logic rs_match;
    logic rt_match;
    logic hazard;
    logic bubble;
    logic [CNT_WIDTH-1:0] stall_count_q;

    // lw and addi take their second operand from the immediate. Only R-type and sw read Rt.
    assign uses_rt  = ~ALUSrc | MemWrite;
    assign rs_match = (ex_q.rt == Rs);
    assign rt_match = uses_rt & (ex_q.rt == Rt);

    // A load in EX whose destination feeds ID. Writes to $0 are never real dependencies.
    assign hazard = ex_q.valid & ex_q.ctrl.mem_read & (ex_q.rt != '0) & (rs_match | rt_match);

    // A flushed instruction is discarded, so it must not hold the PC. Reset forces Stall low.
    assign Stall     = hazard & ~Flush & ~reset;
    assign PCWrite   = ~Stall;
    assign IFIDWrite = ~Stall;
    assign bubble    = Flush | Stall;

    // Gather the ID-stage fields into the EX payload format.
    always_comb begin
        id_bundle                 = '0;
        id_bundle.ctrl.alu_op     = ALUOp;
        id_bundle.ctrl.mem_read   = MemRead;
        id_bundle.ctrl.mem_write  = MemWrite;
        id_bundle.ctrl.mem_to_reg = MemtoReg;
        id_bundle.ctrl.reg_dst    = RegDst;
        id_bundle.ctrl.reg_write  = RegWrite;
        id_bundle.ctrl.alu_src    = ALUSrc;
        id_bundle.read_data1      = ReadData1;
        id_bundle.read_data2      = ReadData2;
        id_bundle.imm             = SignExtImm;
        id_bundle.rs              = Rs;
        id_bundle.rt              = Rt;
        id_bundle.rd              = Rd;
        id_bundle.funct           = Funct;
        id_bundle.valid           = 1'b1;
    end

    // Flush and stall both load an all-zero bubble. A bubble has MemRead low, so it cannot raise a hazard on the next cycle.
    always_comb begin
        ex_next = id_bundle;
        if (bubble) begin
            ex_next = '0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_next;
        end
    end

    // Count stall cycles for debug. The counter saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (Stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign EX_ALUOp     = ex_q.ctrl.alu_op;
    assign EX_MemRead   = ex_q.ctrl.mem_read;
    assign EX_MemWrite  = ex_q.ctrl.mem_write;
    assign EX_MemtoReg  = ex_q.ctrl.mem_to_reg;
    assign EX_RegDst    = ex_q.ctrl.reg_dst;
    assign EX_RegWrite  = ex_q.ctrl.reg_write;
    assign EX_ALUSrc    = ex_q.ctrl.alu_src;
    assign EX_ReadData1 = ex_q.read_data1;
    assign EX_ReadData2 = ex_q.read_data2;
    assign EX_Imm       = ex_q.imm;
    assign EX_Rs        = ex_q.rs;
    assign EX_Rt        = ex_q.rt;
    assign EX_Rd        = ex_q.rd;
    assign EX_Funct     = ex_q.funct;
    assign EX_Valid     = ex_q.valid;
    assign StallCount   = stall_count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute. Captures the control bundle from the opcode control unit, the register-file operands, the immediate and the register specifiers.
- Contains the load-use hazard detector. It stalls the PC and the IF/ID register and injects a bubble into EX when a lw in EX feeds the instruction in ID.
- Supports a branch flush and provides a saturating stall-cycle counter for debug.

Parameters:
DATA_WIDTH, 32, operand/immediate width
REG_ADDR_WIDTH, 5, register specifier width
CNT_WIDTH, 16, stall counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Flush  input  1  discard the instruction in ID (branch taken); EX receives a bubble
ALUOp  input  2  from control unit
MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc  input  1 each  from control unit
ReadData1, ReadData2  input  DATA_WIDTH  register file outputs
SignExtImm  input  DATA_WIDTH  sign-extended immediate
Rs, Rt, Rd  input  REG_ADDR_WIDTH  ID-stage specifiers
Funct  input  6  instruction[5:0]
Stall  output  1  combinational; load-use hazard detected
PCWrite, IFIDWrite  output  1  combinational; equal to ~Stall
EX_ALUOp  output  2  registered
EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegDst, EX_RegWrite, EX_ALUSrc  output  1 each  registered
EX_ReadData1, EX_ReadData2, EX_Imm  output  DATA_WIDTH  registered
EX_Rs, EX_Rt, EX_Rd  output  REG_ADDR_WIDTH  registered
EX_Funct  output  6  registered
EX_Valid  output  1  registered; 0 marks a bubble
StallCount  output  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (async, active-high):
  - All EX_* outputs clear to 0, including EX_Valid.
  - StallCount clears to 0.
  - Stall is 0 while reset is asserted.
- Hazard condition is combinational:
  - Hazard = EX_Valid & EX_MemRead & (EX_Rt != 0) & ((EX_Rt == Rs) | (UsesRt & (EX_Rt == Rt))).
  - UsesRt = (~ALUSrc) | MemWrite. This covers R-type and sw; lw and addi do not read Rt.
- Stall = Hazard & ~Flush. PCWrite = IFIDWrite = ~Stall.
- Each rising edge, priority is reset > Flush > Stall > normal:
  - Flush=1: load bubble. All EX_* control bits = 0 and EX_Valid = 0. Data and specifier fields are don't-care; the implementation drives them to 0.
  - Stall=1: load bubble, same as Flush. ID holds because IFIDWrite = 0, so the same instruction is re-evaluated next cycle.
  - Otherwise: capture all inputs into EX_* and set EX_Valid = 1. X inputs (e.g. RegDst/MemtoReg on sw) are captured verbatim.
- Bubble guarantees EX_RegWrite = EX_MemWrite = EX_MemRead = 0. A bubble can therefore never raise a hazard next cycle, so a single lw causes at most one stall cycle.
- Latency:
  - One cycle from ID inputs to EX_* outputs.
  - Load-use costs exactly one bubble.
- StallCount increments by 1 on each edge where Stall=1. It holds at all-ones (no wrap).
- Flush and Hazard in the same cycle: Flush wins. Stall=0, so the PC advances and the discarded instruction never stalls.
- Reset mid-stall: next cycle starts from the all-zero state. No hazard, Stall=0.
- Register 0: a lw targeting $0 never stalls.

Test Plan:
- Reset, then ID presents R-type (ALUOp=10, RegWrite=1, Rs=1, Rt=2, Rd=3, ReadData1=0x5) -> after one edge, EX_ALUOp=10, EX_Rd=3, EX_ReadData1=0x5, EX_Valid=1, Stall=0.
- lw $4 in EX (EX_MemRead=1, EX_Rt=4), ID add with Rs=4 -> Stall=1 and PCWrite=0 that cycle; next edge EX_Valid=0 and all EX controls 0; following edge add enters EX with Stall=0; StallCount=1.
- lw $4 in EX, ID addi with Rt=4, Rs=7 (ALUSrc=1) -> Stall=0; addi captured normally.
- lw $4 in EX, ID sw with Rt=4 -> Stall=1, one bubble.
- lw $0 in EX, ID add Rs=0 -> Stall=0.
- lw $4 in EX, ID add Rs=4 with Flush=1 -> Stall=0, PCWrite=1; next edge bubble. Then assert reset mid-operation -> all EX_* and StallCount immediately 0.
